// File: rtl/eth_mac_filter_multi.sv
// Destination-address filter for the Ethernet receive path.
// Snoops the first six bytes of each frame, compares them against a
// programmable unicast table plus broadcast/multicast/promiscuous modes,
// and produces a per-frame accept/drop verdict with saturating statistics.
module eth_mac_filter_multi #(
  parameter int          N_ADDR    = 2,
  parameter int          SLOT_W    = 3,
  parameter logic [47:0] RESET_MAC = 48'hFEFAF6F2EEEA,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              byte_we,
  input  logic [7:0]        d,
  input  logic              promisc,
  input  logic              en_bcast,
  input  logic              en_mcast,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [2:0]        cfg_sel,
  input  logic [7:0]        cfg_data,
  output logic              cfg_busy,
  input  logic              cnt_clr,
  output logic              n_inhibit,
  output logic              decision,
  output logic              hit,
  output logic [SLOT_W-1:0] match_idx,
  output logic [CNT_W-1:0]  accept_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [47:0]        addr_r [N_ADDR];
  logic [N_ADDR-1:0]  en_r;
  logic [N_ADDR-1:0]  match_vec_r, base_match_s, new_match_s;
  logic               bcast_ok_r, base_bcast_s, new_bcast_s;
  logic               mcast_r, new_mcast_s;
  logic [2:0]         byte_cnt_r, base_cnt_s, new_cnt_s;
  logic               take_s, last_s, accept_s;
  logic [SLOT_W-1:0]  idx_s;
  logic [7:0]         slot_byte_s;
  logic               cfg_busy_r, n_inhibit_r, decision_r, hit_r;
  logic [SLOT_W-1:0]  match_idx_r;
  logic [CNT_W-1:0]   accept_cnt_r, drop_cnt_r;

  // Per-byte comparison: a frame_start restarts from fresh state in the same
  // cycle, so a coincident byte_we is treated as byte 0 of the new frame.
  always_comb begin
    base_match_s = frame_start ? en_r : match_vec_r;
    base_bcast_s = frame_start ? 1'b1 : bcast_ok_r;
    base_cnt_s   = frame_start ? 3'd0 : byte_cnt_r;
    take_s       = (frame_start | (state_r == S_CMP)) & byte_we & (base_cnt_s < 3'd6);
    new_match_s  = base_match_s;
    new_bcast_s  = base_bcast_s;
    new_mcast_s  = mcast_r;
    new_cnt_s    = base_cnt_s;
    slot_byte_s  = 8'd0;
    if (take_s) begin
      for (int i = 0; i < N_ADDR; i++) begin
        slot_byte_s    = 8'(addr_r[i] >> (6'd40 - {base_cnt_s, 3'b000}));
        new_match_s[i] = base_match_s[i] & (d == slot_byte_s);
      end
      new_bcast_s = base_bcast_s & (d == 8'hFF);
      if (base_cnt_s == 3'd0) begin
        new_mcast_s = d[0];
      end else begin
        new_mcast_s = mcast_r;
      end
      new_cnt_s = base_cnt_s + 3'd1;
    end else begin
      new_cnt_s = base_cnt_s;
    end
    last_s   = take_s & (base_cnt_s == 3'd5);
    accept_s = promisc | (en_bcast & new_bcast_s) |
               (en_mcast & new_mcast_s & ~new_bcast_s) | (|new_match_s);
  end

  // Lowest-numbered matching slot (scan high to low so the lowest wins).
  always_comb begin
    idx_s = {SLOT_W{1'b0}};
    for (int i = N_ADDR - 1; i >= 0; i--) begin
      if (new_match_s[i]) begin
        idx_s = SLOT_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  // Next-state: any frame_start (re)enters CMP; the sixth byte finalises.
  always_comb begin
    state_s = state_r;
    if (frame_start) begin
      state_s = S_CMP;
    end else if (last_s) begin
      state_s = S_DONE;
    end else begin
      state_s = state_r;
    end
  end

  // State register, comparison progress and verdict outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cfg_busy_r  <= 1'b0;
      match_vec_r <= {N_ADDR{1'b0}};
      bcast_ok_r  <= 1'b1;
      mcast_r     <= 1'b0;
      byte_cnt_r  <= 3'd0;
      decision_r  <= 1'b0;
      n_inhibit_r <= 1'b1;
      hit_r       <= 1'b0;
      match_idx_r <= {SLOT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      cfg_busy_r <= (state_s == S_CMP);
      decision_r <= last_s;
      if (frame_start || (state_r == S_CMP)) begin
        match_vec_r <= new_match_s;
        bcast_ok_r  <= new_bcast_s;
        mcast_r     <= new_mcast_s;
        byte_cnt_r  <= new_cnt_s;
      end
      if (frame_start) begin
        n_inhibit_r <= 1'b1;
        hit_r       <= 1'b0;
      end else if (last_s) begin
        n_inhibit_r <= accept_s;
        hit_r       <= |new_match_s;
        match_idx_r <= idx_s;
      end
    end
  end

  // Address table: slot 0 comes up as the reset MAC; writes blocked in CMP.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ADDR; i++) begin
        addr_r[i] <= (i == 0) ? RESET_MAC : 48'd0;
      end
      en_r <= N_ADDR'(1'b1);
    end else if (cfg_we && (state_r != S_CMP)) begin
      for (int i = 0; i < N_ADDR; i++) begin
        if (cfg_slot == SLOT_W'(i)) begin
          case (cfg_sel)
            3'd0:    addr_r[i][47:40] <= cfg_data;
            3'd1:    addr_r[i][39:32] <= cfg_data;
            3'd2:    addr_r[i][31:24] <= cfg_data;
            3'd3:    addr_r[i][23:16] <= cfg_data;
            3'd4:    addr_r[i][15:8]  <= cfg_data;
            3'd5:    addr_r[i][7:0]   <= cfg_data;
            3'd6:    en_r[i]          <= cfg_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      accept_cnt_r <= {CNT_W{1'b0}};
      drop_cnt_r   <= {CNT_W{1'b0}};
    end else if (last_s) begin
      if (accept_s) begin
        if (accept_cnt_r != {CNT_W{1'b1}}) accept_cnt_r <= accept_cnt_r + CNT_W'(1);
      end else begin
        if (drop_cnt_r != {CNT_W{1'b1}}) drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
    end
  end

  assign cfg_busy   = cfg_busy_r;
  assign n_inhibit  = n_inhibit_r;
  assign decision   = decision_r;
  assign hit        = hit_r;
  assign match_idx  = match_idx_r;
  assign accept_cnt = accept_cnt_r;
  assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_eth_mac_filter_multi.sv
// Directed, table-driven bench for eth_mac_filter_multi (4-bit counters).
module tb_eth_mac_filter_multi;

  logic       clk, rst, frame_start, byte_we, promisc, en_bcast, en_mcast;
  logic       cfg_we, cfg_busy, cnt_clr, n_inhibit, decision, hit;
  logic [7:0] d, cfg_data;
  logic [2:0] cfg_slot, cfg_sel, match_idx;
  logic [3:0] accept_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;
  int dec_cnt = 0;
  int exp_acc = 0;
  int exp_drop = 0;
  int dec_base;

  typedef struct {
    logic [47:0] addr;
    logic        p, b, m;
    logic        exp_accept, exp_hit;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t vecs[11];

  eth_mac_filter_multi #(
    .N_ADDR(2), .SLOT_W(3), .RESET_MAC(48'hFEFAF6F2EEEA), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .byte_we(byte_we), .d(d),
    .promisc(promisc), .en_bcast(en_bcast), .en_mcast(en_mcast),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_busy(cfg_busy), .cnt_clr(cnt_clr), .n_inhibit(n_inhibit),
    .decision(decision), .hit(hit), .match_idx(match_idx),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (decision === 1'b1) dec_cnt++;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Caller is just past a negedge; returns at the negedge where the verdict shows.
  task automatic send_frame(input logic [47:0] a, input logic cc);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      byte_we = 1'b1;
      d = a[47 - 8*k -: 8];
      if (k == 5) cnt_clr = cc;
      @(negedge clk);
    end
    byte_we = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] slot, input logic [2:0] sel, input logic [7:0] data);
    cfg_we = 1'b1; cfg_slot = slot; cfg_sel = sel; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic model_count(input logic acc);
    if (acc) exp_acc = (exp_acc == 15) ? 15 : exp_acc + 1;
    else     exp_drop = (exp_drop == 15) ? 15 : exp_drop + 1;
  endtask

  task automatic run_vec(input int i);
    promisc = vecs[i].p; en_bcast = vecs[i].b; en_mcast = vecs[i].m;
    send_frame(vecs[i].addr, 1'b0);
    chk($sformatf("v%0d decision", i), decision, 1'b1);
    chk($sformatf("v%0d n_inhibit", i), n_inhibit, vecs[i].exp_accept);
    chk($sformatf("v%0d hit", i), hit, vecs[i].exp_hit);
    if (vecs[i].exp_hit) chk($sformatf("v%0d match_idx", i), match_idx, vecs[i].exp_idx);
    model_count(vecs[i].exp_accept);
    chk($sformatf("v%0d accept_cnt", i), accept_cnt, exp_acc);
    chk($sformatf("v%0d drop_cnt", i), drop_cnt, exp_drop);
    @(negedge clk);
    chk($sformatf("v%0d decision_pulse", i), decision, 1'b0);
    chk($sformatf("v%0d n_inhibit_hold", i), n_inhibit, vecs[i].exp_accept);
  endtask

  initial begin
    vecs[0]  = '{48'hFEFAF6F2EEEA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
    vecs[1]  = '{48'hFEFAF6F2EEEB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{48'hFEFAF6F2EEEB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[3]  = '{48'hFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[4]  = '{48'hFFFFFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[5]  = '{48'h01005E000001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[6]  = '{48'h01005E000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[7]  = '{48'h000000000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{48'h020000000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
    vecs[9]  = '{48'hFEFAF6F2EEEA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{48'h000000000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

    rst = 1'b1; frame_start = 1'b0; byte_we = 1'b0; d = 8'd0;
    promisc = 1'b0; en_bcast = 1'b0; en_mcast = 1'b0;
    cfg_we = 1'b0; cfg_slot = 3'd0; cfg_sel = 3'd0; cfg_data = 8'd0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst n_inhibit", n_inhibit, 1'b1);
    chk("rst decision", decision, 1'b0);
    chk("rst hit", hit, 1'b0);
    chk("rst match_idx", match_idx, 3'd0);
    chk("rst cfg_busy", cfg_busy, 1'b0);
    chk("rst accept_cnt", accept_cnt, 4'd0);
    chk("rst drop_cnt", drop_cnt, 4'd0);

    // Default table: reset MAC in slot 0 only
    for (int i = 0; i < 8; i++) run_vec(i);

    // Slot 1 = 02:00:00:00:00:01 enabled, slot 0 disabled
    cfg_write(3'd1, 3'd0, 8'h02);
    for (int s = 1; s < 5; s++) cfg_write(3'd1, 3'(s), 8'h00);
    cfg_write(3'd1, 3'd5, 8'h01);
    cfg_write(3'd1, 3'd6, 8'h01);
    cfg_write(3'd0, 3'd6, 8'h00);
    for (int i = 8; i < 11; i++) run_vec(i);

    // Runt frame, blocked cfg write, then frame_start coincident with byte 0
    promisc = 1'b0; en_bcast = 1'b0; en_mcast = 1'b0;
    dec_base = dec_cnt;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("cmp cfg_busy", cfg_busy, 1'b1);
    cfg_we = 1'b1; cfg_slot = 3'd1; cfg_sel = 3'd0; cfg_data = 8'hAA;
    byte_we = 1'b1; d = 8'h02;
    @(negedge clk);
    cfg_we = 1'b0;
    d = 8'h00; @(negedge clk);
    d = 8'h00; @(negedge clk);
    frame_start = 1'b1; d = 8'h02; @(negedge clk);
    frame_start = 1'b0;
    for (int k = 1; k < 6; k++) begin
      d = (k == 5) ? 8'h01 : 8'h00;
      @(negedge clk);
    end
    byte_we = 1'b0;
    chk("runt decision", decision, 1'b1);
    chk("runt n_inhibit", n_inhibit, 1'b1);
    chk("runt hit", hit, 1'b1);
    chk("runt match_idx", match_idx, 3'd1);
    model_count(1'b1);
    chk("runt accept_cnt", accept_cnt, exp_acc);
    chk("runt drop_cnt", drop_cnt, exp_drop);
    repeat (3) @(negedge clk);
    chk("runt decision_count", dec_cnt - dec_base, 1);

    // Saturation of drop_cnt
    cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
    exp_acc = 0; exp_drop = 0;
    chk("clr accept_cnt", accept_cnt, 4'd0);
    chk("clr drop_cnt", drop_cnt, 4'd0);
    for (int n = 0; n < 17; n++) begin
      send_frame(48'hFEFAF6F2EEEA, 1'b0);
      model_count(1'b0);
      if (n >= 15) chk($sformatf("sat drop_cnt %0d", n), drop_cnt, exp_drop);
      @(negedge clk);
    end
    chk("sat accept_cnt", accept_cnt, 4'd0);

    // cnt_clr coincident with a decision
    send_frame(48'h020000000001, 1'b1);
    chk("clrdec decision", decision, 1'b1);
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clrdec accept_cnt", accept_cnt, 4'd0);
    chk("clrdec drop_cnt", drop_cnt, 4'd0);

    // Reset in the middle of a frame (during byte 3)
    dec_base = dec_cnt;
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    byte_we = 1'b1;
    d = 8'h02; @(negedge clk);
    d = 8'h00; @(negedge clk);
    d = 8'h00; rst = 1'b1; @(negedge clk);
    rst = 1'b0; byte_we = 1'b0;
    chk("midrst n_inhibit", n_inhibit, 1'b1);
    chk("midrst decision", decision, 1'b0);
    chk("midrst cfg_busy", cfg_busy, 1'b0);
    chk("midrst match_idx", match_idx, 3'd0);
    byte_we = 1'b1;
    for (int k = 0; k < 6; k++) begin d = 8'h00; @(negedge clk); end
    byte_we = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst no_decision", dec_cnt - dec_base, 0);
    chk("midrst idle n_inhibit", n_inhibit, 1'b1);
    send_frame(48'hFEFAF6F2EEEA, 1'b0);
    chk("midrst table n_inhibit", n_inhibit, 1'b1);
    chk("midrst table hit", hit, 1'b1);
    chk("midrst table match_idx", match_idx, 3'd0);
    chk("midrst accept_cnt", accept_cnt, 4'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_mac_filter_multi.md
Name: eth_mac_filter_multi

Overview:
- Synchronous, parametrised destination-address filter for the Ethernet receive path.
- Snoops the first six bytes of each frame as they are written into the receive buffer.
- Compares them against a programmable table of unicast addresses, plus broadcast, multicast and promiscuous modes.
- Drives n_inhibit to drop non-matching frames and keeps saturating accept/drop statistics.

Parameters:
N_ADDR, 2, number of unicast address slots (1..8)
SLOT_W, 3, width of slot index; must satisfy 2**SLOT_W >= N_ADDR
RESET_MAC, 48'hFEFAF6F2EEEA, address loaded into slot 0 on reset; byte 0 = bits 47:40
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset, synchronous, active-high
frame_start  in  1  one-cycle pulse at start of received frame
byte_we  in  1  one-cycle strobe per received byte written to buffer
d  in  8  received byte, valid with byte_we
promisc  in  1  accept all frames
en_bcast  in  1  accept FF:FF:FF:FF:FF:FF
en_mcast  in  1  accept any address with byte0 bit0 = 1
cfg_we  in  1  table write strobe
cfg_slot  in  SLOT_W  slot to write
cfg_sel  in  3  0..5 = address byte, 6 = slot enable (cfg_data[0]), 7 = ignored
cfg_data  in  8  write data
cfg_busy  out  1  high in CMP state; cfg_we ignored while high
cnt_clr  in  1  clears both counters
n_inhibit  out  1  0 = drop current frame
decision  out  1  one-cycle pulse when verdict is final
hit  out  1  unicast slot matched (valid with decision, held until next frame_start)
match_idx  out  SLOT_W  lowest matching slot index (valid when hit)
accept_cnt  out  CNT_W  accepted frames, saturating
drop_cnt  out  CNT_W  dropped frames, saturating

Behaviour:
- Reset values:
  - State IDLE.
  - n_inhibit=1, decision=0, hit=0, match_idx=0, cfg_busy=0.
  - Counters 0.
  - Slot 0 = RESET_MAC, enabled; all other slots disabled with address 0.
- States:
  - IDLE: after reset.
  - CMP: comparing bytes.
  - DONE: verdict held.
- Any state, frame_start:
  - Go to CMP with byte_cnt=0.
  - match_vec = slot enable bits.
  - bcast_ok=1.
  - n_inhibit=1, hit=0.
- frame_start with byte_we in the same cycle: that byte is byte 0 of the new frame.
- CMP, byte_we with byte_cnt=k (0..5):
  - match_vec[i] &= (d == slot[i].byte[k]).
  - bcast_ok &= (d == 8'hFF).
  - When k=0, mcast = d[0].
  - byte_cnt increments.
- On byte_we with k=5, registered at the next clock edge:
  - decision=1 for one cycle.
  - accept = promisc | (en_bcast & bcast_ok) | (en_mcast & mcast & ~bcast_ok) | (|match_vec).
  - n_inhibit = accept.
  - hit = |match_vec; match_idx = lowest set bit.
  - State goes to DONE.
  - Latency: verdict visible exactly one cycle after the 6th byte_we.
- Broadcast with en_bcast=0: accepted only if promisc is set; en_mcast does not admit broadcast.
- promisc, en_bcast and en_mcast are sampled on the decision cycle only.
- DONE: further byte_we ignored; outputs hold until the next frame_start.
- Frame_start while in CMP (runt/aborted frame): restart the comparison. The aborted frame yields no decision and no count.
- IDLE: byte_we ignored.
- Table writes:
  - Take effect one cycle after cfg_we.
  - Allowed in IDLE/DONE only; cfg_busy = (state==CMP).
  - Writes with cfg_slot >= N_ADDR are ignored.
- Counters:
  - On the decision cycle, accept_cnt or drop_cnt increments, saturating at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
- rst mid-frame: aborts; all reset values apply, including the table.

Test Plan:
1. Reset, then frame_start and bytes FE FA F6 F2 EE EA -> decision one cycle after 6th byte_we, n_inhibit=1, hit=1, match_idx=0, accept_cnt=1.
2. Frame FE FA F6 F2 EE EB, modes off -> n_inhibit=0, hit=0, drop_cnt=1. Same frame with promisc=1 -> n_inhibit=1, hit=0.
3. Program slot 1 = 02:00:00:00:00:01 and enable it; also disable slot 0. Frame 02 00 00 00 00 01 -> hit=1, match_idx=1. Frame FE FA F6 F2 EE EA -> dropped.
4. Frame FF×6: with en_bcast=0, en_mcast=1 -> dropped; with en_bcast=1 -> accepted. Frame 01 00 5E 00 00 01 with en_mcast=1 -> accepted.
5. frame_start after 3 bytes, then a full matching frame -> exactly one decision pulse and one count. A cfg_we issued during CMP is ignored (cfg_busy=1), verified by a readback frame.
6. Preload drop_cnt to all-ones via 2**CNT_W drops (CNT_W=4 build), then another drop -> count stays 15. cnt_clr together with a decision -> 0. rst during byte 3 -> IDLE, n_inhibit=1, no decision.
